// File: rtl/rv32ic_fetch_align_pkg.sv
// Shared types and helpers for the RV32IC fetch aligner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: RV_HW_W, rv_halfword_t, rv32ic_t (raw instruction view), rv_is_compressed().
package rv32ic_fetch_align_pkg;

  localparam int RV_HW_W = 16;

  typedef logic [RV_HW_W-1:0] rv_halfword_t;

  // Raw instruction as handed to decode; compressed ones are zero-extended
  // and expanded further downstream.
  typedef logic [31:0] rv32ic_t;

  // RVC encodings use quadrants 0..2; quadrant 3 marks a 32-bit instruction.
  function automatic logic rv_is_compressed(input rv_halfword_t hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/rv32ic_fetch_align.sv
// Splits word-aligned fetch words into halfwords and presents one whole RVC or 32-bit instruction.
// Latency: a word accepted at edge N makes its instruction visible in cycle N+1.
// Backpressure: fetch_ready only while <=1 halfword is buffered; the instruction holds until instr_ready.
// Ports: clk, reset_n (sync, active low), redirect_valid/redirect_pc (flush + restart),
//        fetch_valid/fetch_addr/fetch_data/fetch_ready (word in),
//        instr_valid/instr_ready/instr/instr_pc/instr_compressed (instruction out).
module rv32ic_fetch_align
  import rv32ic_fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        instr_valid,
  input  logic        instr_ready,
  output rv32ic_t     instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  // Halfword buffer, hb[0] is the oldest; only the first cnt entries are live.
  rv_halfword_t hb   [3];
  rv_halfword_t hb_n [3];
  logic [1:0]   cnt;
  logic [31:0]  buf_pc;    // byte PC of hb[0]
  logic [31:0]  exp_addr;  // next word address we are willing to take
  logic         skip_lo;   // next accepted word starts at its upper halfword

  logic         head_c;
  logic         consume;
  logic         accept;
  logic [1:0]   n_cons;
  logic [1:0]   n_app;
  logic [1:0]   rem;

  assign head_c = rv_is_compressed(hb[0]);

  // Decode gating depends on registers and redirect only, never on instr_ready.
  assign fetch_ready = reset_n & ~redirect_valid & (cnt <= 2'd1);
  assign instr_valid = reset_n & (((cnt != 2'd0) & head_c) | (cnt >= 2'd2));

  assign instr            = head_c ? {16'h0000, hb[0]} : {hb[1], hb[0]};
  assign instr_pc         = buf_pc;
  assign instr_compressed = head_c;

  // A redirect cancels any handshake that happens in the same cycle.
  assign consume = instr_valid & instr_ready & ~redirect_valid;
  // Words whose address is not the expected one are stale (pre-redirect) and
  // are swallowed without touching state.
  assign accept  = fetch_valid & fetch_ready & (fetch_addr == exp_addr);

  assign n_cons = consume ? (head_c ? 2'd1 : 2'd2) : 2'd0;
  assign n_app  = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
  assign rem    = cnt - n_cons;

  // Pop from the head, then append after whatever remains. Accept implies
  // cnt<=1, so rem is 0 or 1 and the append never overruns the 3 entries.
  always_comb begin
    hb_n[0] = hb[0];
    hb_n[1] = hb[1];
    hb_n[2] = hb[2];
    case (n_cons)
      2'd1: begin
        hb_n[0] = hb[1];
        hb_n[1] = hb[2];
      end
      2'd2: hb_n[0] = hb[2];
      default: ;
    endcase
    if (accept) begin
      if (skip_lo) begin
        if (rem == 2'd0) hb_n[0] = fetch_data[31:16];
        else             hb_n[1] = fetch_data[31:16];
      end else begin
        if (rem == 2'd0) begin
          hb_n[0] = fetch_data[15:0];
          hb_n[1] = fetch_data[31:16];
        end else begin
          hb_n[1] = fetch_data[15:0];
          hb_n[2] = fetch_data[31:16];
        end
      end
    end
  end

  // Buffer contents are qualified by cnt, so they need no reset.
  always_ff @(posedge clk) begin
    hb[0] <= hb_n[0];
    hb[1] <= hb_n[1];
    hb[2] <= hb_n[2];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= 2'd0;
      exp_addr <= RESET_PC & ~32'h3;
      skip_lo  <= RESET_PC[1];
      buf_pc   <= RESET_PC & ~32'h1;
    end else if (redirect_valid) begin
      cnt      <= 2'd0;
      exp_addr <= redirect_pc & ~32'h3;
      skip_lo  <= redirect_pc[1];
      buf_pc   <= redirect_pc & ~32'h1;
    end else begin
      cnt <= rem + n_app;
      if (accept) begin
        exp_addr <= exp_addr + 32'd4;
        skip_lo  <= 1'b0;
      end
      if (consume) begin
        buf_pc <= buf_pc + (head_c ? 32'd2 : 32'd4);
      end
    end
  end

endmodule
